// File: rtl/gbt_link_sequencer.sv
// GBT link bring-up sequencer: reset, wait for TX/RX/lock, stability window,
// link-up supervision with retry and failure handling.
// Optional LOS debounce filter: define GBT_LINK_SEQ_LOS_FILTER_EN.
module gbt_link_sequencer #(
    parameter int unsigned RESET_CYCLES      = 256,
    parameter int unsigned TIMEOUT_CYCLES    = 4_000_000,
    parameter int unsigned STABLE_CYCLES     = 40_000,
    parameter int unsigned MAX_RETRIES       = 8,
    parameter int unsigned LOS_FILTER_CYCLES = 1024
) (
    input  logic        clk_ik,
    input  logic        rst_irn,
    input  logic        sfp_los_i,
    input  logic        tx_ready_i,
    input  logic        rx_ready_i,
    input  logic        link_ready_i,
    input  logic        restart_i,
    output logic        gbt_reset_o,
    output logic        bitslip_reset_o,
    output logic        link_up_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic [15:0] lost_cnt_o
);

    // One counter width sized for the largest cycle-count parameter.
    localparam int unsigned MAX_AB = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD = (STABLE_CYCLES > LOS_FILTER_CYCLES) ? STABLE_CYCLES : LOS_FILTER_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        S_LOS       = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_TX   = 3'd2,
        S_WAIT_RX   = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_STABLE    = 3'd5,
        S_UP        = 3'd6,
        S_FAIL      = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [15:0]      lost_q, lost_d;
    logic             go_retry, enter;
    logic             los_m, los_s, los_f;

    // Two-flop synchronizer for the asynchronous SFP LOS input.
    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            los_m <= 1'b1;
            los_s <= 1'b1;
        end else begin
            los_m <= sfp_los_i;
            los_s <= los_m;
        end
    end

`ifdef GBT_LINK_SEQ_LOS_FILTER_EN
    logic [CNT_W-1:0] flt_cnt_q;

    // Debounce: accept a new LOS level only after it has held for the full window.
    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            los_f     <= 1'b1;
            flt_cnt_q <= '0;
        end else if (los_s == los_f) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == CNT_W'(LOS_FILTER_CYCLES - 1)) begin
            los_f     <= los_s;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + CNT_W'(1);
        end
    end
`else
    assign los_f = los_s;
`endif

    // Counter preload for the state being entered; the state lasts preload+1 cycles.
    function automatic logic [CNT_W-1:0] reload(input state_t s);
        case (s)
            S_RESET:                           reload = CNT_W'(RESET_CYCLES - 1);
            S_WAIT_TX, S_WAIT_RX, S_WAIT_LOCK: reload = CNT_W'(TIMEOUT_CYCLES - 1);
            S_STABLE:                          reload = CNT_W'(STABLE_CYCLES - 1);
            default:                           reload = '0;
        endcase
    endfunction

    // Next-state, counter and retry bookkeeping; priority LOS > restart > timeout/loss > advance.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        lost_d   = lost_q;
        go_retry = 1'b0;
        enter    = 1'b0;

        if (los_f) begin
            state_d = S_LOS;
            retry_d = '0;
            enter   = 1'b1;
        end else if (restart_i && (state_q != S_LOS)) begin
            state_d = S_RESET;
            retry_d = '0;
            enter   = 1'b1;
        end else begin
            case (state_q)
                S_LOS: begin
                    state_d = S_RESET;
                    enter   = 1'b1;
                end
                S_RESET: begin
                    if (cnt_q == '0) begin
                        state_d = S_WAIT_TX;
                        enter   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT_TX: begin
                    if (cnt_q == '0) begin
                        go_retry = 1'b1;
                    end else if (tx_ready_i) begin
                        state_d = S_WAIT_RX;
                        enter   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT_RX: begin
                    if (cnt_q == '0) begin
                        go_retry = 1'b1;
                    end else if (rx_ready_i) begin
                        state_d = S_WAIT_LOCK;
                        enter   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (cnt_q == '0) begin
                        go_retry = 1'b1;
                    end else if (link_ready_i) begin
                        state_d = S_STABLE;
                        enter   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!link_ready_i) begin
                        go_retry = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = S_UP;
                        enter   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_UP: begin
                    if (!(tx_ready_i && rx_ready_i && link_ready_i)) begin
                        go_retry = 1'b1;
                    end
                end
                default: begin
                    state_d = S_FAIL;
                end
            endcase

            if (go_retry) begin
                enter = 1'b1;
                if ((9'(retry_q) + 9'd1) == 9'(MAX_RETRIES)) begin
                    state_d = S_FAIL;
                    retry_d = 8'(MAX_RETRIES);
                end else begin
                    state_d = S_RESET;
                    retry_d = retry_q + 8'd1;
                end
            end
        end

        if (enter) begin
            cnt_d = reload(state_d);
        end

        if ((state_q == S_UP) && (state_d != S_UP) && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end
    end

    // State register with Moore outputs decoded from the next state so they switch with it.
    always_ff @(posedge clk_ik or negedge rst_irn) begin
        if (!rst_irn) begin
            state_q         <= S_LOS;
            cnt_q           <= '0;
            retry_q         <= '0;
            lost_q          <= '0;
            gbt_reset_o     <= 1'b1;
            bitslip_reset_o <= 1'b1;
            link_up_o       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            retry_q         <= retry_d;
            lost_q          <= lost_d;
            gbt_reset_o     <= state_d inside {S_LOS, S_RESET, S_FAIL};
            bitslip_reset_o <= state_d inside {S_LOS, S_RESET, S_WAIT_TX, S_WAIT_RX, S_FAIL};
            link_up_o       <= (state_d == S_UP);
        end
    end

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign lost_cnt_o  = lost_q;

endmodule
